// File: rtl/alu_mdu.sv
// ALU with an iterative multiply/divide unit and architectural HI/LO registers.
// Single-cycle ops finish at the start edge; mult/div run one bit per cycle on
// operand magnitudes and apply the signs on the final edge.
module alu_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
   typedef enum logic [1:0] {KSingle, KIllegal, KMul, KDiv} kind_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / partial remainder
   logic [WIDTH-1:0]   shr_q, shr_d;     // multiplier / dividend-quotient shifter
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // |b|: multiplicand or divisor
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;
   logic               illegal_q, illegal_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   kind_e              kind;
   logic               op_signed;
   logic [WIDTH-1:0]   alu_res;

   // Operation decode and single-cycle datapath.
   always_comb begin
      kind      = KSingle;
      op_signed = 1'b0;
      alu_res   = '0;
      case (aluop)
         3'b000: alu_res = a + b;
         3'b001: alu_res = a - b;
         3'b011: alu_res = a & b;
         3'b100: alu_res = a | b;
         3'b101: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         3'b110: alu_res = a ^ b;
         3'b111: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         default: begin
            case (funct)
               6'b100000, 6'b100001: alu_res = a + b;
               6'b100010, 6'b100011: alu_res = a - b;
               6'b100100: alu_res = a & b;
               6'b100101: alu_res = a | b;
               6'b100110: alu_res = a ^ b;
               6'b100111: alu_res = ~(a | b);
               6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
               6'b101011: alu_res = {{(WIDTH-1){1'b0}}, a < b};
               6'b010000: alu_res = hi_q;
               6'b010010: alu_res = lo_q;
               6'b011000: begin kind = KMul; op_signed = 1'b1; end
               6'b011001: kind = KMul;
               6'b011010: begin kind = KDiv; op_signed = 1'b1; end
               6'b011011: kind = KDiv;
               default:   kind = KIllegal;
            endcase
         end
      endcase
   end

   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [WIDTH-1:0]   mul_acc, mul_shr, div_acc, div_shr, rem_sub;
   logic [WIDTH-1:0]   quo_fix, rem_fix, mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic               ge, sa, sb;

   // One shift-add / restoring shift-subtract step plus final sign fix-up.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : '0);
      mul_acc  = mul_sum[WIDTH:1];
      mul_shr  = {mul_sum[0], shr_q[WIDTH-1:1]};
      rem_sh   = {acc_q, shr_q[WIDTH-1]};
      ge       = rem_sh >= {1'b0, opnd_q};
      rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
      div_acc  = ge ? rem_sub : rem_sh[WIDTH-1:0];
      div_shr  = {shr_q[WIDTH-2:0], ge};
      prod_fix = (neg_a_q ^ neg_b_q) ? -{mul_acc, mul_shr} : {mul_acc, mul_shr};
      quo_fix  = (neg_a_q ^ neg_b_q) ? -div_shr : div_shr;
      // A zero divisor leaves |a| in the remainder, so this also yields hi = a.
      rem_fix  = neg_a_q ? -div_acc : div_acc;
      sa       = op_signed & a[WIDTH-1];
      sb       = op_signed & b[WIDTH-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
   end

   // Next-state logic for the FSM and all architectural state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      shr_d     = shr_q;
      opnd_d    = opnd_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      result_d  = result_q;
      zero_d    = zero_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               unique case (kind)
                  KSingle: begin
                     result_d = alu_res;
                     zero_d   = (alu_res == '0);
                     done_d   = 1'b1;
                  end
                  KIllegal: begin
                     result_d  = '0;
                     zero_d    = 1'b1;
                     done_d    = 1'b1;
                     illegal_d = 1'b1;
                  end
                  default: begin
                     state_d = (kind == KMul) ? StMul : StDiv;
                     cnt_d   = CntW'(WIDTH);
                     acc_d   = '0;
                     shr_d   = mag_a;
                     opnd_d  = mag_b;
                     neg_a_d = sa;
                     neg_b_d = sb;
                  end
               endcase
            end
         end
         StMul: begin
            cnt_d = cnt_q - CntW'(1);
            acc_d = mul_acc;
            shr_d = mul_shr;
            if (cnt_q == CntW'(1)) begin
               {hi_d, lo_d} = prod_fix;
               done_d       = 1'b1;
               state_d      = StIdle;
            end
         end
         StDiv: begin
            cnt_d = cnt_q - CntW'(1);
            acc_d = div_acc;
            shr_d = div_shr;
            if (cnt_q == CntW'(1)) begin
               hi_d    = rem_fix;
               lo_d    = (opnd_q == '0) ? '1 : quo_fix;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         shr_q     <= '0;
         opnd_q    <= '0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         shr_q     <= shr_d;
         opnd_q    <= opnd_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign illegal = illegal_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu (WIDTH=32): directed literal checks plus randomized traffic,
// every cycle compared against an arithmetic reference model.
module tb_alu_mdu;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   aluop = 3'b000;
   logic [5:0]   funct = 6'b000000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] result, hi, lo;
   logic         zero, busy, done, illegal;

   alu_mdu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
      .a(a), .b(b), .result(result), .zero(zero), .busy(busy), .done(done),
      .illegal(illegal), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [W-1:0] m_result, m_hi, m_lo, p_hi, p_lo;
   logic         m_zero, m_busy, m_done, m_ill;
   int           m_cnt;

   logic [5:0] funct_list [0:15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                     6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19,
                                     6'h1A, 6'h1B};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic single(input logic [W-1:0] v);
      m_result = v;
      m_zero   = (v == '0);
      m_done   = 1'b1;
   endtask

   // Apply the effect of one rising edge, using the inputs presented to it.
   task automatic model_edge();
      logic [5:0]  f;
      logic [63:0] prod;
      int          sa, sb;
      if (!reset) begin
         m_result = '0; m_zero = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ill = 1'b0;
         m_hi = '0; m_lo = '0; m_cnt = 0;
         return;
      end
      m_done = 1'b0;
      m_ill  = 1'b0;
      if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
         end
      end else if (start) begin
         case (aluop)
            3'b000:  f = 6'h20;
            3'b001:  f = 6'h22;
            3'b011:  f = 6'h24;
            3'b100:  f = 6'h25;
            3'b101:  f = 6'h2A;
            3'b110:  f = 6'h26;
            3'b111:  f = 6'h2B;
            default: f = funct;
         endcase
         sa = $signed(a);
         sb = $signed(b);
         case (f)
            6'h20, 6'h21: single(a + b);
            6'h22, 6'h23: single(a - b);
            6'h24: single(a & b);
            6'h25: single(a | b);
            6'h26: single(a ^ b);
            6'h27: single(~(a | b));
            6'h2A: single((sa < sb) ? 32'd1 : 32'd0);
            6'h2B: single((a < b) ? 32'd1 : 32'd0);
            6'h10: single(m_hi);
            6'h12: single(m_lo);
            6'h18, 6'h19, 6'h1A, 6'h1B: begin
               if (f == 6'h18) begin
                  prod = longint'(sa) * longint'(sb);
                  {p_hi, p_lo} = prod;
               end else if (f == 6'h19) begin
                  prod = {32'b0, a} * {32'b0, b};
                  {p_hi, p_lo} = prod;
               end else if (b == '0) begin
                  p_lo = '1; p_hi = a;
               end else if (f == 6'h1A && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  p_lo = a; p_hi = '0;
               end else if (f == 6'h1A) begin
                  p_lo = sa / sb; p_hi = sa % sb;
               end else begin
                  p_lo = a / b; p_hi = a % b;
               end
               m_busy = 1'b1;
               m_cnt  = W;
            end
            default: begin
               m_result = '0; m_zero = 1'b1; m_done = 1'b1; m_ill = 1'b1;
            end
         endcase
      end
   endtask

   // One clock: update the model at the edge, then compare every output.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("result", result, m_result);
      chk("zero", zero, m_zero);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("illegal", illegal, m_ill);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   endtask

   task automatic op(input logic [2:0] ao, input logic [5:0] fn,
                     input logic [W-1:0] av, input logic [W-1:0] bv);
      aluop = ao; funct = fn; a = av; b = bv; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return $urandom_range(0, 9);
         default: return $urandom();
      endcase
   endfunction

   int dones;

   initial begin
      // Reset state.
      reset = 1'b0;
      step();
      step();
      chk("rst_result", result, 32'h0);
      chk("rst_zero", zero, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_hilo", {hi, lo}, 64'h0);
      reset = 1'b1;
      step();

      // R-type sub wraps.
      op(3'b010, 6'b100010, 32'd5, 32'd7);
      chk("sub_result", result, 32'hFFFF_FFFE);
      chk("sub_zero", zero, 1'b0);
      chk("sub_done", done, 1'b1);
      step();
      chk("sub_done_drop", done, 1'b0);

      // slt vs sltu on the same operands.
      op(3'b101, 6'b000000, 32'hFFFF_FFFF, 32'd1);
      chk("slt", result, 32'd1);
      op(3'b111, 6'b000000, 32'hFFFF_FFFF, 32'd1);
      chk("sltu", result, 32'd0);
      chk("sltu_zero", zero, 1'b1);

      // Signed and unsigned multiply of 0xFFFFFFFF * 2.
      op(3'b010, 6'b011000, 32'hFFFF_FFFF, 32'd2);
      chk("mult_busy", busy, 1'b1);
      repeat (31) step();
      chk("mult_busy31", busy, 1'b1);
      chk("mult_nodone31", done, 1'b0);
      step();
      chk("mult_done", done, 1'b1);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      op(3'b010, 6'b011001, 32'hFFFF_FFFF, 32'd2);
      repeat (32) step();
      chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

      // Signed divide -7/2, then divide by zero.
      op(3'b010, 6'b011010, 32'hFFFF_FFF9, 32'd2);
      repeat (32) step();
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      op(3'b010, 6'b011010, 32'hFFFF_FFF9, 32'd0);
      repeat (32) step();
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'hFFFF_FFF9);
      chk("div0_illegal", illegal, 1'b0);

      // Signed overflow.
      op(3'b010, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (32) step();
      chk("ovf_lo", lo, 32'h8000_0000);
      chk("ovf_hi", hi, 32'h0);

      // Undecodable funct.
      op(3'b010, 6'b111111, 32'd1, 32'd2);
      chk("ill_done", done, 1'b1);
      chk("ill_flag", illegal, 1'b1);
      chk("ill_result", result, 32'h0);
      chk("ill_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

      // Start during a multiply is ignored; exactly one done pulse.
      dones = 0;
      op(3'b010, 6'b011000, 32'd3, 32'd5);
      repeat (5) step();
      aluop = 3'b010; funct = 6'b100000; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 28; i++) begin
         step();
         if (done === 1'b1) dones++;
      end
      chk("ignored_start_dones", dones, 1);
      op(3'b010, 6'b010010, 32'd0, 32'd0);
      chk("mflo", result, 32'd15);
      op(3'b010, 6'b010000, 32'd0, 32'd0);
      chk("mfhi", result, 32'd0);

      // Reset 10 cycles into a divide aborts it.
      op(3'b010, 6'b011010, 32'd100, 32'd7);
      repeat (9) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_hilo", {hi, lo}, 64'h0);
      op(3'b010, 6'b011011, 32'd100, 32'd7);
      repeat (32) step();
      chk("divu_after_abort", {hi, lo}, {32'd2, 32'd14});

      // Randomized traffic.
      for (int i = 0; i < 6000; i++) begin
         reset = ($urandom_range(0, 299) != 0);
         start = ($urandom_range(0, 3) != 0);
         aluop = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
         funct = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                              : funct_list[$urandom_range(0, 15)];
         a = rnd_val();
         b = rnd_val();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits; legal values are even integers 8..64.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 aluop  input  3  operation class: 000 add, 001 sub, 010 R-type (use funct), 011 and, 100 or, 101 slt, 110 xor, 111 sltu.
REQ-006 funct  input  6  R-type function code, used only when aluop=010.
REQ-007 a  input  WIDTH  operand A (rs).
REQ-008 b  input  WIDTH  operand B (rt/immediate).
REQ-009 result  output  WIDTH  registered result of the last completed operation.
REQ-010 zero  output  1  registered; 1 when result is all zeros.
REQ-011 busy  output  1  1 while an iterative operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 illegal  output  1  valid with done; 1 when the opcode was undecodable.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 R-type funct decode SHALL be: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-016 add/sub SHALL wrap modulo 2^WIDTH with no overflow trap; slt/sltu SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-017 The FSM SHALL have states IDLE, MUL, DIV; reset state IDLE.
REQ-018 IDLE, start=1, single-cycle op (all except mult/multu/div/divu): at that edge result, zero and done=1 are registered; latency 1 cycle; the FSM stays in IDLE.
REQ-019 IDLE, start=1, mult/multu: operands and signedness latched, counter loaded with WIDTH, busy=1, next state MUL.
REQ-020 IDLE, start=1, div/divu: same as REQ-019, next state DIV.
REQ-021 MUL/DIV SHALL process one operand bit per cycle (shift-add / restoring shift-subtract on magnitudes) and decrement the counter each edge.
REQ-022 On the edge where the counter reaches 0: hi/lo written, busy=0, done=1, FSM to IDLE; done is first visible WIDTH cycles after the start edge.
REQ-023 mult/multu: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned; result is not updated.
REQ-024 div/divu: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign; result is not updated.
REQ-025 Divide by zero SHALL complete with normal latency: lo = all ones, hi = a; illegal=0.
REQ-026 Signed overflow (a = most-negative value, b = -1) SHALL give lo = a, hi = 0.
REQ-027 start while busy=1 SHALL be ignored with no side effects; a, b, aluop and funct may change freely during MUL/DIV.
REQ-028 mfhi/mflo SHALL read the hi/lo value current at the start edge.
REQ-029 Undecodable funct under aluop=010 SHALL give done=1, illegal=1, result=0; hi, lo and FSM state unchanged.
REQ-030 done and illegal SHALL be 0 in every cycle not covered by REQ-018/022/029; back-to-back starts in IDLE SHALL produce a done pulse every cycle.

Reset
REQ-031 With reset=0 at a rising edge: result=0, zero=1, busy=0, done=0, illegal=0, hi=0, lo=0, counter=0, FSM=IDLE.
REQ-032 Reset during MUL/DIV SHALL abort the operation with no done pulse and hi/lo cleared.
REQ-033 start SHALL be ignored in any cycle where reset=0.

Verification (WIDTH=32)
REQ-034 aluop=010, funct=100010, a=5, b=7, start=1 -> next cycle result=0xFFFFFFFE, zero=0, done=1.
REQ-035 funct=011000, a=0xFFFFFFFF, b=2 -> busy for 32 cycles, then done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; repeat with 011001 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 funct=011010, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
REQ-037 During a mult, pulse start with funct=100000 -> ignored; only one done pulse occurs, at the 32-cycle point; then mflo returns the product.
REQ-038 reset=0 asserted 10 cycles into a div -> busy=0, no done, hi=lo=0; next op completes normally.
REQ-039 aluop=010, funct=111111 -> done=1, illegal=1, result=0, hi/lo unchanged.
